csi_rx_dly_cal: RTL and testbench

// - Per-lane IDELAY tap calibrator for the CSI data PHY. Sweeps the lane IDELAY tap 0..31 while
//   HS bursts arrive, scores each tap by SoT hits in the deserialised byte stream, then programs
//   the centre of the longest passing run. Sits beside each csi_rx_phy_dat. Drives its

---
 rtl/csi_rx_dly_cal.sv | 230 +++++++++++++++++++++++
 tb/tb_csi_rx_dly_cal.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_dly_cal.sv
// Per-lane IDELAY tap calibrator: sweeps taps 0..31, scores SoT hits per tap, loads the eye centre.
// Optional macro CSI_DLY_CAL_MAP_EN exposes the per-tap pass map as good_map_o.
module csi_rx_dly_cal #(
  parameter logic [4:0]  DEFAULT_TAP = 5'd3,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned WIN_CYC     = 4096,
  parameter int unsigned MIN_HITS    = 4,
  parameter int unsigned MIN_EYE     = 3
) (
  input  logic        byte_clock,
  input  logic        reset_n,
  input  logic        cal_start,
  input  logic [7:0]  deser_byte,
  output logic [4:0]  dly_cnt,
  output logic        dly_ld,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [5:0]  eye_len,
`ifdef CSI_DLY_CAL_MAP_EN
  output logic [31:0] good_map_o,
`endif
  output logic [2:0]  dbg_state
);

  // cal_start is a one-cycle request with no ready: it is taken only in IDLE and dropped otherwise.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_SCAN    = 3'd4,
    S_APPLY   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] WIN_LAST    = 16'(WIN_CYC - 1);
  localparam logic [15:0] MIN_HITS_W  = 16'(MIN_HITS);
  localparam logic [5:0]  MIN_EYE_W   = 6'(MIN_EYE);

  state_t      state_q, state_d;
  logic [4:0]  tap_q, tap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [7:0]  prev1_q, prev1_d;
  logic [7:0]  prev2_q, prev2_d;
  logic [31:0] good_map_q, good_map_d;
  logic [4:0]  scan_i_q, scan_i_d;
  logic [4:0]  cur_start_q, cur_start_d;
  logic [5:0]  cur_len_q, cur_len_d;
  logic [4:0]  best_start_q, best_start_d;
  logic [5:0]  best_len_q, best_len_d;
  logic [4:0]  dly_cnt_q, dly_cnt_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic [5:0]  eye_len_q, eye_len_d;

  logic [23:0] w24;
  logic        hit;
  logic [15:0] hit_sum;
  logic [5:0]  run_len;
  logic [4:0]  run_start;
  logic [5:0]  half_len;
  logic        ld_o;

  // 0xB8 following HS-zero, searched at every bit alignment across the 3-byte history.
  always_comb begin
    w24 = {deser_byte, prev1_q, prev2_q};
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (w24[k +: 16] == 16'hB800) hit = 1'b1;
    end
  end

  assign hit_sum  = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + {15'd0, hit};
  assign half_len = (best_len_q - 6'd1) >> 1;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    hit_cnt_d    = hit_cnt_q;
    prev1_d      = deser_byte;
    prev2_d      = prev1_q;
    good_map_d   = good_map_q;
    scan_i_d     = scan_i_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    dly_cnt_d    = dly_cnt_q;
    done_d       = done_q;
    fail_d       = fail_q;
    eye_len_d    = eye_len_q;
    run_len      = 6'd0;
    run_start    = 5'd0;
    ld_o         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          state_d    = S_LOAD;
          tap_d      = 5'd0;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          good_map_d = 32'd0;
        end
      end
      S_LOAD: begin
        dly_cnt_d = tap_q;
        ld_o      = 1'b1;
        prev1_d   = 8'd0;
        prev2_d   = 8'd0;
        hit_cnt_d = 16'd0;
        cnt_d     = 16'd0;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_MEASURE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MEASURE: begin
        hit_cnt_d = hit_sum;
        if (cnt_q == WIN_LAST) begin
          good_map_d[tap_q] = (hit_sum >= MIN_HITS_W);
          cnt_d = 16'd0;
          if (tap_q == 5'd31) begin
            state_d      = S_SCAN;
            scan_i_d     = 5'd0;
            cur_start_d  = 5'd0;
            cur_len_d    = 6'd0;
            best_start_d = 5'd0;
            best_len_d   = 6'd0;
          end else begin
            tap_d   = tap_q + 5'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SCAN: begin
        // Strictly-longer replaces the best, so equal runs keep the lower start.
        if (good_map_q[scan_i_q]) begin
          run_len     = cur_len_q + 6'd1;
          run_start   = (cur_len_q == 6'd0) ? scan_i_q : cur_start_q;
          cur_len_d   = run_len;
          cur_start_d = run_start;
          if (run_len > best_len_q) begin
            best_len_d   = run_len;
            best_start_d = run_start;
          end
        end else begin
          cur_len_d = 6'd0;
        end
        if (scan_i_q == 5'd31) state_d = S_APPLY;
        else                   scan_i_d = scan_i_q + 5'd1;
      end
      S_APPLY: begin
        ld_o      = 1'b1;
        eye_len_d = best_len_q;
        if (best_len_q >= MIN_EYE_W) begin
          dly_cnt_d = best_start_q + half_len[4:0];
          done_d    = 1'b1;
        end else begin
          dly_cnt_d = DEFAULT_TAP;
          fail_d    = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge byte_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      tap_q        <= 5'd0;
      cnt_q        <= 16'd0;
      hit_cnt_q    <= 16'd0;
      prev1_q      <= 8'd0;
      prev2_q      <= 8'd0;
      good_map_q   <= 32'd0;
      scan_i_q     <= 5'd0;
      cur_start_q  <= 5'd0;
      cur_len_q    <= 6'd0;
      best_start_q <= 5'd0;
      best_len_q   <= 6'd0;
      dly_cnt_q    <= DEFAULT_TAP;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_len_q    <= 6'd0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      prev1_q      <= prev1_d;
      prev2_q      <= prev2_d;
      good_map_q   <= good_map_d;
      scan_i_q     <= scan_i_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      dly_cnt_q    <= dly_cnt_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_len_q    <= eye_len_d;
    end
  end

  // dly_cnt is presented in the same cycle as the load strobe, then held in dly_cnt_q.
  assign dly_cnt   = dly_cnt_d;
  assign dly_ld    = ld_o;
  assign cal_busy  = (state_q != S_IDLE);
  assign cal_done  = done_q;
  assign cal_fail  = fail_q;
  assign eye_len   = eye_len_q;
  assign dbg_state = state_q;

`ifdef CSI_DLY_CAL_MAP_EN
  assign good_map_o = good_map_q;
`endif

endmodule

// File: tb/tb_csi_rx_dly_cal.sv
// Bench for csi_rx_dly_cal: per-tap byte stream model, load-value scoreboard, result checks.
module tb_csi_rx_dly_cal;

  localparam int S_CYC    = 4;
  localparam int W_CYC    = 256;
  localparam int SWEEP_LAT = 32 * (1 + S_CYC + W_CYC) + 32 + 1;

  logic        byte_clock = 1'b0;
  logic        reset_n    = 1'b0;
  logic        cal_start  = 1'b0;
  logic [7:0]  deser_byte = 8'h00;
  logic [4:0]  dly_cnt;
  logic        dly_ld;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [5:0]  eye_len;
  logic [2:0]  dbg_state;
`ifdef CSI_DLY_CAL_MAP_EN
  logic [31:0] good_map_o;
`endif

  csi_rx_dly_cal #(
    .DEFAULT_TAP(5'd3),
    .SETTLE_CYC (S_CYC),
    .WIN_CYC    (W_CYC),
    .MIN_HITS   (4),
    .MIN_EYE    (3)
  ) dut (
    .byte_clock(byte_clock),
    .reset_n   (reset_n),
    .cal_start (cal_start),
    .deser_byte(deser_byte),
    .dly_cnt   (dly_cnt),
    .dly_ld    (dly_ld),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail),
    .eye_len   (eye_len),
`ifdef CSI_DLY_CAL_MAP_EN
    .good_map_o(good_map_o),
`endif
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 byte_clock = ~byte_clock;

  int cyc = 0;
  always @(posedge byte_clock) cyc++;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard of expected dly_cnt values, one per dly_ld strobe
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  logic [31:0] pass_mask = 32'd0;
  bit          three_hit = 1'b0;
  bit          active    = 1'b0;
  logic [4:0]  cur_tap   = 5'd0;
  int          since_ld  = 0;
  int          apply_cyc = -1;
  int          start_cyc = 0;
  logic        prev_ld   = 1'b0;

  // Hits land at fixed offsets after each load: one in the last settle cycle (must be
  // ignored) and the rest in the window, the final one on the window's last cycle.
  function automatic logic [7:0] byte_for(input int c, input logic [4:0] tap);
    logic [23:0] v;
    int          hits[5];
    hits = '{S_CYC, 60, 120, 180, S_CYC + W_CYC};
    v = 24'hB800 << tap[2:0];
    byte_for = 8'h00;
    if (pass_mask[tap]) begin
      for (int j = 0; j < 5; j++) begin
        if (!(three_hit && j == 3)) begin
          if (c == hits[j] - 2)      byte_for = v[7:0];
          else if (c == hits[j] - 1) byte_for = v[15:8];
          else if (c == hits[j])     byte_for = v[23:16];
        end
      end
    end
  endfunction

  // monitor + stream driver
  always @(negedge byte_clock) begin
    if (dly_ld) begin
      check_eq("ld_gap", prev_ld, 0);
      if (exp_q.size() == 0) begin
        check_eq("ld_extra", dly_ld, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("ld_tap", dly_cnt, mon_exp);
        if (exp_q.size() == 0) apply_cyc = cyc;
      end
      active   = 1'b1;
      cur_tap  = dly_cnt;
      since_ld = 0;
    end else if (since_ld < 100000) begin
      since_ld++;
    end
    prev_ld    = dly_ld;
    deser_byte = active ? byte_for(since_ld + 1, cur_tap) : 8'h00;
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge byte_clock);
    cal_start = 1'b1;
    start_cyc = cyc;
    @(negedge byte_clock);
    cal_start = 1'b0;
  endtask

  task automatic run_sweep(input logic [31:0] mask, input bit thr, input int exp_tap,
                           input int exp_eye, input bit exp_ok, input bit mid);
    bit finished;
    pass_mask = mask;
    three_hit = thr;
    exp_q.delete();
    for (int t = 0; t < 32; t++) exp_q.push_back(t);
    exp_q.push_back(exp_tap);
    apply_cyc = -1;
    pulse_start();
    check_eq("busy_start", cal_busy, 1);
    check_eq("done_clr", cal_done, 0);
    finished = 1'b0;
    for (int i = 0; i < SWEEP_LAT + 100; i++) begin
      @(negedge byte_clock);
      cal_start = (mid && i == 3000);
      if (!cal_busy) begin
        finished = 1'b1;
        break;
      end
    end
    cal_start = 1'b0;
    check_eq("finished", finished, 1);
    check_eq("done", cal_done, exp_ok);
    check_eq("fail", cal_fail, !exp_ok);
    check_eq("eye_len", eye_len, exp_eye);
    check_eq("final_tap", dly_cnt, exp_tap);
    check_eq("ld_count", exp_q.size(), 0);
    check_eq("latency", apply_cyc - start_cyc, SWEEP_LAT);
    repeat (5) @(negedge byte_clock);
    check_eq("hold_tap", dly_cnt, exp_tap);
    check_eq("hold_done", cal_done, exp_ok);
  endtask

  bit found;

  initial begin
    repeat (3) @(negedge byte_clock);
    reset_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge byte_clock);
      check_eq("idle_tap", dly_cnt, 3);
      check_eq("idle_ld", dly_ld, 0);
      check_eq("idle_busy", cal_busy, 0);
      check_eq("idle_done", cal_done, 0);
      check_eq("idle_fail", cal_fail, 0);
      check_eq("idle_eye", eye_len, 0);
    end

    run_sweep(32'h0007_FC00, 1'b0, 14, 9, 1'b1, 1'b0);   // taps 10..18
    run_sweep(32'h00F0_003C, 1'b0, 3, 4, 1'b1, 1'b0);    // taps 2..5 and 20..23
    run_sweep(32'h0000_0000, 1'b0, 3, 0, 1'b0, 1'b0);    // no hits
    run_sweep(32'hFFFF_FFFF, 1'b1, 3, 0, 1'b0, 1'b0);    // 3 hits per window
    run_sweep(32'hFFFF_FFFF, 1'b0, 15, 32, 1'b1, 1'b1);  // all pass + ignored mid start

    // abort during tap 7 measure
    pass_mask = 32'hFFFF_FFFF;
    three_hit = 1'b0;
    exp_q.delete();
    for (int t = 0; t < 32; t++) exp_q.push_back(t);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge byte_clock);
      if (cur_tap == 5'd7 && since_ld == 100) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_t7", found, 1);
    check_eq("pre_rst_busy", cal_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_tap", dly_cnt, 3);
    check_eq("rst_ld", dly_ld, 0);
    check_eq("rst_busy", cal_busy, 0);
    check_eq("rst_done", cal_done, 0);
    check_eq("rst_fail", cal_fail, 0);
    check_eq("rst_eye", eye_len, 0);
    exp_q.delete();
    active = 1'b0;
    repeat (3) @(negedge byte_clock);
    check_eq("rst_hold_busy", cal_busy, 0);
    reset_n = 1'b1;
    @(negedge byte_clock);
    check_eq("post_rst_tap", dly_cnt, 3);

    run_sweep(32'hFFFF_FFFF, 1'b0, 15, 32, 1'b1, 1'b0);  // restart from tap 0

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
